ciq_entry_ctrl: RTL and testbench

Entry storage and control for the 16-entry compressed issue queue (CIQ). It exports per-entry free flags to the combinational free-entry allocator and writes up to four dispatched uops into the allocator's returned `free_addr` slots. It tracks source-operand readiness from the wakeup broadcast and selects one ready entry per cycle into a registered issue output stage, returning that entry to the free pool.

---
 rtl/ciq_entry_ctrl.sv | 126 ++++++++++++
 tb/tb_ciq_entry_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ciq_entry_ctrl.sv
// 16-entry issue-queue storage: dispatch write into allocator slots, tag wakeup, lowest-index select.
// Latency: dispatch->selectable 1 cycle, select->iss_valid 1 cycle; issue register holds until iss_ready.
// Backpressure: all-or-nothing dispatch via disp_ready; optional occupancy counter under CIQ_OCC_CNT_EN.
module ciq_entry_ctrl #(
   parameter int INSTR_NUM = 4,
   parameter int CIQ_DEPTH = 16,
   parameter int PAYLOAD_W = 64,
   parameter int TAG_W     = 6
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   output logic [CIQ_DEPTH-1:0]           ciq_free,
   input  logic [4*INSTR_NUM-1:0]         free_addr,
   input  logic [INSTR_NUM-1:0]           free_valid,
   input  logic [INSTR_NUM-1:0]           disp_valid,
   output logic                           disp_ready,
   input  logic [INSTR_NUM*PAYLOAD_W-1:0] disp_payload,
   input  logic [INSTR_NUM*TAG_W-1:0]     disp_src1_tag,
   input  logic [INSTR_NUM*TAG_W-1:0]     disp_src2_tag,
   input  logic [INSTR_NUM-1:0]           disp_src1_rdy,
   input  logic [INSTR_NUM-1:0]           disp_src2_rdy,
   input  logic                           wk_valid,
   input  logic [TAG_W-1:0]               wk_tag,
   output logic                           iss_valid,
   output logic [PAYLOAD_W-1:0]           iss_payload,
   output logic [3:0]                     iss_idx,
   input  logic                           iss_ready,
   output logic [4:0]                     ciq_occ
);

   logic [CIQ_DEPTH-1:0] vld, rdy1, rdy2, cand;
   logic [PAYLOAD_W-1:0] payload [CIQ_DEPTH];
   logic [TAG_W-1:0]     tag1    [CIQ_DEPTH];
   logic [TAG_W-1:0]     tag2    [CIQ_DEPTH];
   logic                 disp_fire, load, cand_any, sel_fire;
   logic [3:0]           sel_idx;
   logic [INSTR_NUM-1:0] wr_rdy1, wr_rdy2;

   assign ciq_free   = ~vld;
   assign disp_ready = &(free_valid | ~disp_valid) & ~flush;
   assign disp_fire  = |disp_valid & disp_ready;
   assign cand       = vld & rdy1 & rdy2;
   assign cand_any   = |cand;
   assign load       = ~iss_valid | iss_ready;
   assign sel_fire   = load & cand_any & ~flush;

   // Descending scan so the lowest-index candidate wins.
   always_comb begin
      sel_idx = '0;
      for (int k = CIQ_DEPTH-1; k >= 0; k--)
         if (cand[k]) sel_idx = 4'(k);
   end

   // A wakeup in the dispatch cycle must not be lost for the uop being written.
   always_comb begin
      wr_rdy1 = '0;
      wr_rdy2 = '0;
      for (int i = 0; i < INSTR_NUM; i++) begin
         wr_rdy1[i] = disp_src1_rdy[i] | (wk_valid & (wk_tag == disp_src1_tag[i*TAG_W +: TAG_W]));
         wr_rdy2[i] = disp_src2_rdy[i] | (wk_valid & (wk_tag == disp_src2_tag[i*TAG_W +: TAG_W]));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld         <= '0;
         rdy1        <= '0;
         rdy2        <= '0;
         iss_valid   <= 1'b0;
         iss_payload <= '0;
         iss_idx     <= '0;
         for (int k = 0; k < CIQ_DEPTH; k++) begin
            payload[k] <= '0;
            tag1[k]    <= '0;
            tag2[k]    <= '0;
         end
      end else if (flush) begin
         vld       <= '0;
         iss_valid <= 1'b0;
      end else begin
         if (wk_valid)
            for (int k = 0; k < CIQ_DEPTH; k++) begin
               if (vld[k] && tag1[k] == wk_tag) rdy1[k] <= 1'b1;
               if (vld[k] && tag2[k] == wk_tag) rdy2[k] <= 1'b1;
            end
         if (load) iss_valid <= cand_any;
         if (sel_fire) begin
            iss_payload  <= payload[sel_idx];
            iss_idx      <= sel_idx;
            vld[sel_idx] <= 1'b0;
         end
         // Allocator only hands out free slots, so these never hit the selected entry.
         if (disp_fire)
            for (int i = 0; i < INSTR_NUM; i++)
               if (disp_valid[i]) begin
                  vld    [free_addr[4*i +: 4]] <= 1'b1;
                  payload[free_addr[4*i +: 4]] <= disp_payload[i*PAYLOAD_W +: PAYLOAD_W];
                  tag1   [free_addr[4*i +: 4]] <= disp_src1_tag[i*TAG_W +: TAG_W];
                  tag2   [free_addr[4*i +: 4]] <= disp_src2_tag[i*TAG_W +: TAG_W];
                  rdy1   [free_addr[4*i +: 4]] <= wr_rdy1[i];
                  rdy2   [free_addr[4*i +: 4]] <= wr_rdy2[i];
               end
      end
   end

`ifdef CIQ_OCC_CNT_EN
   logic [2:0] disp_cnt;

   always_comb begin
      disp_cnt = '0;
      for (int i = 0; i < INSTR_NUM; i++)
         disp_cnt = disp_cnt + 3'(disp_valid[i]);
   end

   always_ff @(posedge clk) begin
      if (rst || flush)
         ciq_occ <= '0;
      else
         ciq_occ <= ciq_occ + (disp_fire ? {2'b00, disp_cnt} : 5'd0) - (sel_fire ? 5'd1 : 5'd0);
   end
`else
   assign ciq_occ = '0;
`endif

endmodule

// File: tb/tb_ciq_entry_ctrl.sv
// Bench for ciq_entry_ctrl: directed scenarios plus randomized traffic against an entry-array model.
module tb_ciq_entry_ctrl;
   localparam int N  = 4;
   localparam int D  = 16;
   localparam int PW = 64;
   localparam int TW = 6;
`ifdef CIQ_OCC_CNT_EN
   localparam bit OCC_EN = 1'b1;
`else
   localparam bit OCC_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst, flush;
   logic [D-1:0]    ciq_free;
   logic [4*N-1:0]  free_addr;
   logic [N-1:0]    free_valid, disp_valid;
   logic            disp_ready;
   logic [N*PW-1:0] disp_payload;
   logic [N*TW-1:0] disp_src1_tag, disp_src2_tag;
   logic [N-1:0]    disp_src1_rdy, disp_src2_rdy;
   logic            wk_valid;
   logic [TW-1:0]   wk_tag;
   logic            iss_valid;
   logic [PW-1:0]   iss_payload;
   logic [3:0]      iss_idx;
   logic            iss_ready;
   logic [4:0]      ciq_occ;

   always #5 clk = ~clk;

   ciq_entry_ctrl dut (
      .clk(clk), .rst(rst), .flush(flush), .ciq_free(ciq_free),
      .free_addr(free_addr), .free_valid(free_valid), .disp_valid(disp_valid),
      .disp_ready(disp_ready), .disp_payload(disp_payload),
      .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .wk_valid(wk_valid), .wk_tag(wk_tag), .iss_valid(iss_valid),
      .iss_payload(iss_payload), .iss_idx(iss_idx), .iss_ready(iss_ready),
      .ciq_occ(ciq_occ)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: one record per queue slot plus the issue register.
   bit          m_vld [D];
   bit          m_r1  [D];
   bit          m_r2  [D];
   logic [63:0] m_pay [D];
   logic [5:0]  m_t1  [D];
   logic [5:0]  m_t2  [D];
   bit          m_iv;
   logic [63:0] m_ip;
   logic [3:0]  m_ii;

   task automatic m_reset();
      for (int k = 0; k < D; k++) begin
         m_vld[k] = 0; m_r1[k] = 0; m_r2[k] = 0;
         m_pay[k] = '0; m_t1[k] = '0; m_t2[k] = '0;
      end
      m_iv = 0; m_ip = '0; m_ii = '0;
   endtask

   function automatic logic [15:0] m_free();
      logic [15:0] f;
      for (int k = 0; k < D; k++) f[k] = !m_vld[k];
      return f;
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int k = 0; k < D; k++) if (m_vld[k]) c++;
      return c;
   endfunction

   // Group accepted only if every requesting lane has a slot and no flush.
   function automatic bit exp_disp_ready();
      bit ok = !flush;
      for (int i = 0; i < N; i++) if (disp_valid[i] && !free_valid[i]) ok = 0;
      return ok;
   endfunction

   task automatic model_step();
      int c;
      logic [3:0] a;
      if (rst) begin
         m_reset();
      end else if (flush) begin
         for (int k = 0; k < D; k++) m_vld[k] = 0;
         m_iv = 0;
      end else begin
         c = -1;
         for (int k = 0; k < D; k++)
            if (c < 0 && m_vld[k] && m_r1[k] && m_r2[k]) c = k;
         if (!m_iv || iss_ready) begin
            if (c >= 0) begin
               m_iv = 1; m_ip = m_pay[c]; m_ii = c[3:0]; m_vld[c] = 0;
            end else m_iv = 0;
         end
         if (wk_valid)
            for (int k = 0; k < D; k++) if (m_vld[k]) begin
               if (m_t1[k] == wk_tag) m_r1[k] = 1;
               if (m_t2[k] == wk_tag) m_r2[k] = 1;
            end
         if (exp_disp_ready() && disp_valid != 0)
            for (int i = 0; i < N; i++) if (disp_valid[i]) begin
               a = free_addr[4*i +: 4];
               m_vld[a] = 1;
               m_pay[a] = disp_payload[i*PW +: PW];
               m_t1[a]  = disp_src1_tag[i*TW +: TW];
               m_t2[a]  = disp_src2_tag[i*TW +: TW];
               m_r1[a]  = disp_src1_rdy[i] || (wk_valid && wk_tag == m_t1[a]);
               m_r2[a]  = disp_src2_rdy[i] || (wk_valid && wk_tag == m_t2[a]);
            end
      end
   endtask

   initial m_reset();

   // Compare on the falling edge, then advance the model with the inputs the DUT samples next.
   always @(negedge clk) begin
      chk("ciq_free", ciq_free, m_free());
      chk("iss_valid", iss_valid, m_iv);
      chk("iss_payload", iss_payload, m_ip);
      chk("iss_idx", iss_idx, m_ii);
      chk("ciq_occ", ciq_occ, OCC_EN ? m_count() : 0);
      chk("disp_ready", disp_ready, exp_disp_ready());
      model_step();
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      disp_valid = '0; free_valid = '0; wk_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic lane(input int i, input logic [3:0] addr, input logic [5:0] t1, input bit r1,
                       input logic [5:0] t2, input bit r2, input logic [63:0] pay);
      disp_valid[i] = 1'b1;
      free_valid[i] = 1'b1;
      free_addr[4*i +: 4]       = addr;
      disp_src1_tag[i*TW +: TW] = t1;
      disp_src2_tag[i*TW +: TW] = t2;
      disp_src1_rdy[i] = r1;
      disp_src2_rdy[i] = r2;
      disp_payload[i*PW +: PW]  = pay;
   endtask

   task automatic rand_cycle();
      logic [3:0] fl [16];
      int nf, n;
      nf = 0;
      for (int k = 0; k < D; k++) if (!m_vld[k]) begin fl[nf] = 4'(k); nf++; end
      idle();
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
         lane(i, 4'd0, 6'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
              6'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, {$urandom, $urandom});
         if (i < nf && $urandom_range(0, 15) != 0) free_addr[4*i +: 4] = fl[i];
         else free_valid[i] = 1'b0;
      end
      wk_valid  = $urandom_range(0, 1) == 1;
      wk_tag    = 6'($urandom_range(0, 7));
      iss_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 47) == 0;
      rst       = $urandom_range(0, 299) == 0;
   endtask

   initial begin
      rst = 1'b1; iss_ready = 1'b1; wk_tag = '0; free_addr = '0;
      disp_payload = '0; disp_src1_tag = '0; disp_src2_tag = '0;
      disp_src1_rdy = '0; disp_src2_rdy = '0;
      idle();
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_free", ciq_free, 16'hFFFF);
      chk("rst_iss_valid", iss_valid, 1'b0);
      chk("rst_occ", ciq_occ, 5'd0);

      // Four ready uops into slots 0..3 drain in index order.
      for (int i = 0; i < 4; i++) lane(i, 4'(i), 6'h00, 1, 6'h00, 1, 64'hA0 + 64'(i));
      tick(); idle();
      chk("disp4_free", ciq_free, 16'hFFF0);
      tick();
      chk("disp4_iss_valid", iss_valid, 1'b1);
      chk("disp4_idx0", iss_idx, 4'd0);
      chk("disp4_pay0", iss_payload, 64'hA0);
      for (int j = 1; j < 4; j++) begin
         tick();
         chk("disp4_idx", iss_idx, 4'(j));
      end
      chk("disp4_free_back", ciq_free, 16'hFFFF);
      tick();
      chk("disp4_drained", iss_valid, 1'b0);

      // Wakeup of tag 2A, plus a same-cycle dispatch of tag 2A caught by the bypass.
      lane(0, 4'd0, 6'h2A, 0, 6'h01, 1, 64'hB0);
      tick(); idle();
      wk_valid = 1'b1; wk_tag = 6'h2A;
      lane(0, 4'd1, 6'h2A, 0, 6'h02, 1, 64'hB1);
      tick(); idle();
      chk("wk_n1_iss_valid", iss_valid, 1'b0);
      tick();
      chk("wk_n2_iss_valid", iss_valid, 1'b1);
      chk("wk_n2_idx", iss_idx, 4'd0);
      tick();
      chk("wk_bypass_idx", iss_idx, 4'd1);
      chk("wk_bypass_pay", iss_payload, 64'hB1);
      tick();

      // Fill 14 never-ready entries, then a 4-lane group with only 2 slots.
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 4; i++) lane(i, 4'(c*4+i), 6'h3F, 0, 6'h3F, 0, 64'hC00 + 64'(c*4+i));
         tick(); idle();
      end
      lane(0, 4'd12, 6'h3F, 0, 6'h3F, 0, 64'hC0C);
      lane(1, 4'd13, 6'h3F, 0, 6'h3F, 0, 64'hC0D);
      tick(); idle();
      iss_ready = 1'b0;
      lane(0, 4'd14, 6'h3F, 1, 6'h3F, 1, 64'hE14);
      lane(1, 4'd15, 6'h3F, 1, 6'h3F, 1, 64'hE15);
      disp_valid[3:2] = 2'b11;
      #1 chk("full_reject_ready", disp_ready, 1'b0);
      tick();
      chk("full_reject_free", ciq_free, 16'hC000);
      disp_valid[3:2] = 2'b00;
      #1 chk("two_lane_ready", disp_ready, 1'b1);
      tick(); idle();
      chk("full_free", ciq_free, 16'h0000);
      chk("full_occ", ciq_occ, OCC_EN ? 5'd16 : 5'd0);
      for (int r = 0; r < 3; r++) begin
         tick();
         chk("stall_valid", iss_valid, 1'b1);
         chk("stall_idx", iss_idx, 4'd14);
         chk("stall_pay", iss_payload, 64'hE14);
         chk("stall_free", ciq_free, 16'h4000);
      end

      // Flush with issue pending; the dispatch offered alongside is dropped.
      flush = 1'b1;
      lane(0, 4'd14, 6'h00, 1, 6'h00, 1, 64'hF0);
      #1 chk("flush_disp_ready", disp_ready, 1'b0);
      tick(); idle();
      iss_ready = 1'b1;
      chk("flush_free", ciq_free, 16'hFFFF);
      chk("flush_iss_valid", iss_valid, 1'b0);
      chk("flush_occ", ciq_occ, 5'd0);

      for (int cyc = 0; cyc < 3000; cyc++) begin
         rand_cycle();
         tick();
      end

      // Reset and flush together mid-traffic act as reset.
      idle();
      rst = 1'b1; flush = 1'b1;
      tick();
      rst = 1'b0; flush = 1'b0;
      chk("midrst_free", ciq_free, 16'hFFFF);
      chk("midrst_iss_valid", iss_valid, 1'b0);
      chk("midrst_pay", iss_payload, 64'h0);
      chk("midrst_idx", iss_idx, 4'd0);
      chk("midrst_occ", ciq_occ, 5'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
